ui_input_conditioner: RTL and testbench
=======================================

# ui_input_conditioner

Core-side input stage that sits directly behind the padring input cells and consumes `ui_PAD2CORE` inside `user_project`. It resynchronises all pad inputs into the `clk_i` domain and rejects glitches shorter than a programmable number of cycles. It reports per-bit rise/fall pulses and queues every change of the filtered input word in a small event FIFO with a valid/ready handshake. It shields downstream logic from asynchronous, bouncing pad signals.

## Interface
- `WIDTH`, 17: number of pad input bits.
- `SYNC_STAGES`, 2: synchroniser flops per bit; legal range ≥2.
- `FILT_CYCLES`, 4: consecutive stable cycles required before a filtered bit changes; legal range ≥1.
- `EVT_DEPTH`, 4: event FIFO depth; must be a power of 2, ≥2.
- `clk_i` input 1: core clock; the only clock.
- `rst_ni` input 1: synchronous, active-low reset.
- `ui_PAD2CORE` input WIDTH: raw asynchronous pad inputs (p2c of input pad cells).
- `data_o` output WIDTH: synchronised, filtered input level.
- `rise_o` output WIDTH: one-cycle pulse per bit on a filtered 0→1 transition.
- `fall_o` output WIDTH: one-cycle pulse per bit on a filtered 1→0 transition.
- `evt_valid_o` output 1: event FIFO non-empty.
- `evt_ready_i` input 1: consumer accepts the head event.
- `evt_data_o` output WIDTH: head event, the filtered word after the change.
- `evt_count_o` output $clog2(EVT_DEPTH+1): FIFO occupancy.
- `evt_overflow_o` output 1: sticky, set when an event was dropped.
- `evt_ovf_clr_i` input 1: clears `evt_overflow_o`.

## Operation
- Synchroniser: a chain of SYNC_STAGES flops per bit. Its last stage is `s`.
- Filter, per bit: counter `cnt` of width $clog2(FILT_CYCLES+1).
  - If `s[i]==data_o[i]`: `cnt<=0`.
  - Else if `cnt==FILT_CYCLES-1`: `data_o[i]<=s[i]`, `cnt<=0`.
  - Else: `cnt<=cnt+1`.
  - A disagreement shorter than FILT_CYCLES cycles never reaches `data_o`.
- Edge outputs are registered at the same edge as the `data_o` update:
  - `rise_o[i] = !old & new`.
  - `fall_o[i] = old & !new`.
  - Both are 0 in every other cycle.
- Event push: occurs at any edge where `data_o` changes in at least one bit. The pushed value is the new `data_o`. Several bits changing at the same edge produce one event.
- FIFO:
  - Show-ahead: `evt_data_o` is valid whenever `evt_valid_o=1`.
  - Pop when `evt_valid_o & evt_ready_i`.
  - Pointers are $clog2(EVT_DEPTH) bits and wrap modulo EVT_DEPTH.
- Push while full without a pop in the same cycle: the event is dropped, the FIFO is unchanged, and `evt_overflow_o<=1`.
- Push and pop in the same cycle:
  - Always accepted, including when full.
  - Count is unchanged.
  - Tail written, head advanced.
- Push and pop when empty: not possible, because `evt_valid_o=0`. The push is enqueued.
- Overflow flag:
  - `evt_ovf_clr_i` has priority over a simultaneous overflow set; the flag reads 0 next cycle.
  - The dropped event in that case is still lost.
- `evt_ready_i` with `evt_valid_o=0` is ignored.

## Timing
- Reset: when `rst_ni=0` at an edge, the following are cleared:
  - sync flops, `cnt`, `data_o`, `rise_o`, `fall_o`
  - FIFO pointers, `evt_count_o`, `evt_overflow_o`
- Resulting output values after reset:
  - `evt_valid_o=0`.
  - `evt_data_o=0`; storage is also cleared.
- Reset applied mid-filter or with a full FIFO discards all pending state. No pulse or event is produced during or on the first cycle after reset.
- Latency: a pad change first sampled at edge 1 appears on `data_o`, `rise_o`/`fall_o` and in the FIFO after edge SYNC_STAGES+FILT_CYCLES. Default: 6 edges.
- `evt_valid_o` rises in the same cycle as the pushing `data_o` change.
- Pop is visible on `evt_count_o` and the head at the next edge.
- Throughput: one event per cycle in and out.

## Configuration
- `UI_INPUT_FILTER_EN`:
  - Defined: the filter described above is compiled in.
  - Undefined: counters are removed and `data_o<=s` every cycle. The FILT_CYCLES parameter is ignored, and latency is SYNC_STAGES+1 edges (3 by default).
  - All edge, event and FIFO behaviour is identical in both builds.

## Test plan
- Reset, then hold `ui_PAD2CORE=0x1FFFF` during `rst_ni=0` → all outputs 0. After release, `data_o=0x1FFFF` exactly 6 edges after the first sampling edge, `rise_o=0x1FFFF` for one cycle, and one event of 0x1FFFF is queued.
- Filter build: 3-cycle high glitch on bit 0 → `data_o`, `rise_o` and FIFO unchanged. A 4-cycle pulse → `data_o[0]` rises, then falls 4 cycles after the pad returns low, giving 2 events, 0x00001 then 0x00000.
- `evt_ready_i=0`, 5 distinct changes → `evt_count_o=4` with the first 4 words in order and `evt_overflow_o=1`. A 1-cycle `evt_ovf_clr_i` clears the flag; the FIFO is unchanged.
- Full FIFO with push and pop in the same cycle → count stays 4, the head advances, the new word is at the tail, and no overflow occurs.
- `rst_ni` pulsed low for 1 cycle with 3 events queued and a filter count in progress → `evt_valid_o=0`, `evt_count_o=0` and `data_o=0` the next cycle, with no spurious pulses.
- Build without `UI_INPUT_FILTER_EN`: a 1-cycle pad pulse on bit 16 (aligned to sampling) → `data_o[16]` high for exactly 1 cycle, 3 edges later, and 2 events (0x10000, 0x00000).

Source files
------------

// File: rtl/ui_input_conditioner.sv
// Pad input conditioner: resync, glitch filter, edge pulses, event FIFO.
// Ports: clk_i/rst_ni (sync low), ui_PAD2CORE in; data/rise/fall out;
// evt_* show-ahead FIFO with valid/ready, count and sticky overflow.
// Macro UI_INPUT_FILTER_EN compiles in the per-bit stability filter.
module ui_input_conditioner #(
  parameter int WIDTH       = 17,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_CYCLES = 4,
  parameter int EVT_DEPTH   = 4
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic [WIDTH-1:0]               ui_PAD2CORE,
  output logic [WIDTH-1:0]               data_o,
  output logic [WIDTH-1:0]               rise_o,
  output logic [WIDTH-1:0]               fall_o,
  output logic                           evt_valid_o,
  input  logic                           evt_ready_i,
  output logic [WIDTH-1:0]               evt_data_o,
  output logic [$clog2(EVT_DEPTH+1)-1:0] evt_count_o,
  output logic                           evt_overflow_o,
  input  logic                           evt_ovf_clr_i
);

  localparam int PW = $clog2(EVT_DEPTH);
  localparam int CW = $clog2(EVT_DEPTH+1);

  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("SYNC_STAGES must be >= 2");
  end
  if (FILT_CYCLES < 1) begin : g_bad_filt
    $error("FILT_CYCLES must be >= 1");
  end
  if (EVT_DEPTH < 2 || (1 << PW) != EVT_DEPTH) begin : g_bad_depth
    $error("EVT_DEPTH must be a power of 2, >= 2");
  end

  logic [WIDTH-1:0] sync [SYNC_STAGES];
  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] data_nx;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync[i] <= '0;
    end else begin
      sync[0] <= ui_PAD2CORE;
      for (int i = 1; i < SYNC_STAGES; i++) sync[i] <= sync[i-1];
    end
  end

  assign s = sync[SYNC_STAGES-1];

`ifdef UI_INPUT_FILTER_EN
  localparam int CNTW = $clog2(FILT_CYCLES+1);
  localparam logic [CNTW-1:0] CNT_MAX = CNTW'(FILT_CYCLES-1);

  logic [CNTW-1:0] cnt    [WIDTH];
  logic [CNTW-1:0] cnt_nx [WIDTH];

  // A bit only follows s after FILT_CYCLES consecutive disagreements.
  always_comb begin
    data_nx = data_o;
    cnt_nx  = cnt;
    for (int i = 0; i < WIDTH; i++) begin
      if (s[i] == data_o[i]) begin
        cnt_nx[i] = '0;
      end else if (cnt[i] == CNT_MAX) begin
        data_nx[i] = s[i];
        cnt_nx[i]  = '0;
      end else begin
        cnt_nx[i] = cnt[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
    end else begin
      cnt <= cnt_nx;
    end
  end
`else
  assign data_nx = s;
`endif

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      data_o <= '0;
      rise_o <= '0;
      fall_o <= '0;
    end else begin
      data_o <= data_nx;
      rise_o <= data_nx & ~data_o;
      fall_o <= ~data_nx & data_o;
    end
  end

  logic [WIDTH-1:0] mem [EVT_DEPTH];
  logic [PW-1:0]    wptr;
  logic [PW-1:0]    rptr;
  logic             push;
  logic             pop;
  logic             full;
  logic             accept;

  assign push   = (data_nx != data_o);
  assign pop    = evt_valid_o & evt_ready_i;
  assign full   = (evt_count_o == CW'(EVT_DEPTH));
  // A pop frees the head slot, so a push is taken even when full.
  assign accept = push & (~full | pop);

  assign evt_valid_o = (evt_count_o != '0);
  assign evt_data_o  = mem[rptr];

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < EVT_DEPTH; i++) mem[i] <= '0;
      wptr           <= '0;
      rptr           <= '0;
      evt_count_o    <= '0;
      evt_overflow_o <= 1'b0;
    end else begin
      if (accept) begin
        mem[wptr] <= data_nx;
        wptr      <= wptr + 1'b1;
      end
      if (pop) rptr <= rptr + 1'b1;
      if (accept & ~pop) begin
        evt_count_o <= evt_count_o + CW'(1);
      end else if (pop & ~accept) begin
        evt_count_o <= evt_count_o - CW'(1);
      end
      if (evt_ovf_clr_i) begin
        evt_overflow_o <= 1'b0;
      end else if (push & ~accept) begin
        evt_overflow_o <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ui_input_conditioner.sv
// Directed bench for ui_input_conditioner with an event scoreboard.
// Covers reset, latency, edges, filter, overflow, full push+pop, reset.
module tb_ui_input_conditioner;

`ifdef UI_INPUT_FILTER_EN
  localparam int L = 6;
`else
  localparam int L = 3;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [16:0] pad;
  logic [16:0] data;
  logic [16:0] rise;
  logic [16:0] fall;
  logic        evt_valid;
  logic        evt_ready;
  logic [16:0] evt_data;
  logic [2:0]  evt_count;
  logic        evt_ovf;
  logic        ovf_clr;

  int passed = 0;
  int total  = 0;
  logic [16:0] q [$];

  always #5 clk = ~clk;

  ui_input_conditioner dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .ui_PAD2CORE    (pad),
    .data_o         (data),
    .rise_o         (rise),
    .fall_o         (fall),
    .evt_valid_o    (evt_valid),
    .evt_ready_i    (evt_ready),
    .evt_data_o     (evt_data),
    .evt_count_o    (evt_count),
    .evt_overflow_o (evt_ovf),
    .evt_ovf_clr_i  (ovf_clr)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic pop_chk(input string tag);
    logic [31:0] e;
    chk({tag, "_valid"}, 32'(evt_valid), 1);
    e = (q.size() > 0) ? 32'(q.pop_front()) : 32'hFFFF_FFFF;
    chk(tag, 32'(evt_data), e);
    evt_ready = 1'b1;
    step();
    evt_ready = 1'b0;
  endtask

  task automatic settle_zero();
    pad = '0;
    q.push_back(17'h0);
    repeat (L + 2) step();
    chk("zero_data", 32'(data), 0);
    pop_chk("zero_evt");
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [16:0] rs;
    rst_n     = 1'b0;
    pad       = 17'h1FFFF;
    evt_ready = 1'b0;
    ovf_clr   = 1'b0;
    repeat (3) step();
    chk("rst_data", 32'(data), 0);
    chk("rst_rise", 32'(rise | fall), 0);
    chk("rst_valid", 32'(evt_valid), 0);
    chk("rst_count", 32'(evt_count), 0);
    chk("rst_evt", 32'(evt_data), 0);
    chk("rst_ovf", 32'(evt_ovf), 0);

    rst_n = 1'b1;
    q.push_back(17'h1FFFF);
    repeat (L - 1) step();
    chk("lat_early", 32'(data), 0);
    step();
    chk("lat_data", 32'(data), 32'h1FFFF);
    chk("lat_rise", 32'(rise), 32'h1FFFF);
    chk("lat_valid", 32'(evt_valid), 1);
    step();
    chk("rise_once", 32'(rise), 0);
    chk("lat_count", 32'(evt_count), 1);
    pop_chk("lat_evt");
    chk("pop_count", 32'(evt_count), 0);

    pad = '0;
    q.push_back(17'h0);
    repeat (L - 1) step();
    chk("fall_early", 32'(data), 32'h1FFFF);
    step();
    chk("fall_pulse", 32'(fall), 32'h1FFFF);
    chk("fall_data", 32'(data), 0);
    step();
    pop_chk("fall_evt");

`ifdef UI_INPUT_FILTER_EN
    rs  = '0;
    pad = 17'h1;
    repeat (3) begin
      step();
      rs |= rise;
    end
    pad = '0;
    repeat (10) begin
      step();
      rs |= rise;
    end
    chk("glitch_rise", 32'(rs), 0);
    chk("glitch_data", 32'(data), 0);
    chk("glitch_count", 32'(evt_count), 0);

    pad = 17'h1;
    q.push_back(17'h1);
    q.push_back(17'h0);
    repeat (4) step();
    pad = '0;
    repeat (12) step();
    chk("pulse_count", 32'(evt_count), 2);
    pop_chk("pulse_evt0");
    pop_chk("pulse_evt1");
`endif

    for (int w = 1; w <= 5; w++) begin
      pad = 17'(w);
      if (w <= 4) q.push_back(17'(w));
      repeat (6) step();
      if (w == 4) begin
        chk("full_count", 32'(evt_count), 4);
        chk("full_noovf", 32'(evt_ovf), 0);
      end
    end
    chk("ovf_count", 32'(evt_count), 4);
    chk("ovf_flag", 32'(evt_ovf), 1);
    chk("ovf_head", 32'(evt_data), 1);
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    chk("ovf_clr", 32'(evt_ovf), 0);
    chk("clr_count", 32'(evt_count), 4);

    pad = 17'h6;
    repeat (L - 1) step();
    chk("pp_head0", 32'(evt_data), 32'(q.pop_front()));
    q.push_back(17'h6);
    evt_ready = 1'b1;
    step();
    evt_ready = 1'b0;
    chk("pp_count", 32'(evt_count), 4);
    chk("pp_ovf", 32'(evt_ovf), 0);
    chk("pp_data", 32'(data), 6);
    for (int i = 0; i < 4; i++) pop_chk("pp_drain");
    chk("pp_empty", 32'(evt_count), 0);

    pad = 17'h10;
    q.push_back(17'h10);
    repeat (6) step();
    pad = 17'h20;
    repeat (6) step();
    pad = 17'h30;
    repeat (6) step();
    chk("pre_rst_count", 32'(evt_count), 3);
    pad = 17'h1FFFF;
    repeat (L - 1) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    q.delete();
    chk("mid_rst_valid", 32'(evt_valid), 0);
    chk("mid_rst_count", 32'(evt_count), 0);
    chk("mid_rst_data", 32'(data), 0);
    chk("mid_rst_edges", 32'(rise | fall), 0);
    step();
    chk("post_rst_edges", 32'(rise | fall), 0);
    chk("post_rst_valid", 32'(evt_valid), 0);
    q.push_back(17'h1FFFF);
    repeat (L + 2) step();
    chk("post_rst_data", 32'(data), 32'h1FFFF);
    chk("post_rst_count", 32'(evt_count), 1);
    pop_chk("post_rst_evt");

    settle_zero();

`ifndef UI_INPUT_FILTER_EN
    pad = 17'h10000;
    q.push_back(17'h10000);
    q.push_back(17'h0);
    step();
    pad = '0;
    step();
    chk("p1_early", 32'(data), 0);
    step();
    chk("p1_high", 32'(data), 32'h10000);
    chk("p1_rise", 32'(rise), 32'h10000);
    step();
    chk("p1_low", 32'(data), 0);
    chk("p1_fall", 32'(fall), 32'h10000);
    step();
    chk("p1_count", 32'(evt_count), 2);
    pop_chk("p1_evt0");
    pop_chk("p1_evt1");
`endif

    chk("sb_empty", 32'(q.size()), 0);
    chk("fifo_empty", 32'(evt_count), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
